// File: rtl/kernel3_gmem_c_s_axi_rd_resp_if.sv
// AXI4 read address/data channel bundle between the gmem_C read master and its responder.
interface kernel3_gmem_c_s_axi_rd_resp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [ID_WIDTH-1:0]   s_arid;
    logic [7:0]            s_arlen;
    logic [1:0]            s_arburst;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [ID_WIDTH-1:0]   s_rid;
    logic [1:0]            s_rresp;
    logic                  s_rlast;

    modport master (
        output s_arvalid, s_araddr, s_arid, s_arlen, s_arburst, s_rready,
        input  s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast
    );

    modport slave (
        input  s_arvalid, s_araddr, s_arid, s_arlen, s_arburst, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast
    );
endinterface

// File: rtl/kernel3_gmem_c_s_axi_rd_resp.sv
// AXI4 read responder over an on-chip array; first R beat 2 cycles after AR, 2-entry skid buffer stalls reads under RREADY backpressure.
// Define KERNEL3_GMEM_C_RD_DECERR_EN to return DECERR for beats outside the array instead of wrapping.
module kernel3_gmem_c_s_axi_rd_resp #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 32,
    parameter int    ID_WIDTH   = 1,
    parameter int    MEM_AW     = 10,
    parameter string MEM_STYLE  = "auto"
) (
    input  logic                  clk,
    input  logic                  reset,
    kernel3_gmem_c_s_axi_rd_resp_if.slave s,
    input  logic                  bd_we,
    input  logic [MEM_AW-1:0]     bd_waddr,
    input  logic [DATA_WIDTH-1:0] bd_wdata
);
    localparam int B  = $clog2(DATA_WIDTH / 8);
    // One spare bit above the word address catches INCR carry out of the top.
    localparam int WW = ADDR_WIDTH - B + 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  arready_q, arready_d;
    logic [WW-1:0]         waddr_q, waddr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  fixed_q, fixed_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;
    logic [1:0]            rd_resp_q, rd_resp_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_dat_q [2];
    logic [DATA_WIDTH-1:0] buf_dat_d [2];
    logic                  buf_last_q [2];
    logic                  buf_last_d [2];
    logic [1:0]            buf_resp_q [2];
    logic [1:0]            buf_resp_d [2];

    (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [0:(2**MEM_AW)-1];
    logic [DATA_WIDTH-1:0] mem_rdat_q;
    logic                  rd_en;
    logic [MEM_AW-1:0]     rd_addr;
    logic                  beat_err;
    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            n;
    logic [DATA_WIDTH-1:0] push_dat;

`ifdef KERNEL3_GMEM_C_RD_DECERR_EN
    assign beat_err = |waddr_q[WW-1:MEM_AW];
`else
    assign beat_err = 1'b0;
`endif

    assign rd_addr  = waddr_q[MEM_AW-1:0];
    assign pop      = (cnt_q != 2'd0) && s.s_rready;
    assign occ      = cnt_q + {1'b0, rd_vld_q};
    assign push_dat = (rd_resp_q == 2'b11) ? '0 : mem_rdat_q;

    assign s.s_arready = arready_q;
    assign s.s_rvalid  = (cnt_q != 2'd0);
    assign s.s_rdata   = buf_dat_q[0];
    assign s.s_rlast   = buf_last_q[0];
    assign s.s_rresp   = buf_resp_q[0];
    assign s.s_rid     = id_q;

    always_comb begin
        state_d    = state_q;
        arready_d  = arready_q;
        waddr_d    = waddr_q;
        id_d       = id_q;
        len_d      = len_q;
        beat_d     = beat_q;
        fixed_d    = fixed_q;
        rd_vld_d   = 1'b0;
        rd_last_d  = rd_last_q;
        rd_resp_d  = rd_resp_q;
        rd_en      = 1'b0;
        buf_dat_d  = buf_dat_q;
        buf_last_d = buf_last_q;
        buf_resp_d = buf_resp_q;
        n          = cnt_q;

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (s.s_arvalid && arready_q) begin
                    waddr_d   = {1'b0, s.s_araddr[ADDR_WIDTH-1:B]};
                    id_d      = s.s_arid;
                    len_d     = s.s_arlen;
                    fixed_d   = (s.s_arburst == 2'b00);
                    beat_d    = 8'd0;
                    arready_d = 1'b0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                // A read issued now lands next cycle; it must fit even if nothing pops then.
                if ((occ < 2'd2) || pop) begin
                    rd_en     = 1'b1;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (beat_q == len_q);
                    rd_resp_d = beat_err ? 2'b11 : 2'b00;
                    beat_d    = beat_q + 8'd1;
                    if (!fixed_q) begin
                        waddr_d = waddr_q + {{(WW-1){1'b0}}, 1'b1};
                    end
                    if (beat_q == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && buf_last_q[0]) begin
                    state_d   = IDLE;
                    arready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            buf_dat_d[0]  = buf_dat_q[1];
            buf_last_d[0] = buf_last_q[1];
            buf_resp_d[0] = buf_resp_q[1];
            n             = n - 2'd1;
        end
        if (rd_vld_q) begin
            buf_dat_d[n[0]]  = push_dat;
            buf_last_d[n[0]] = rd_last_q;
            buf_resp_d[n[0]] = rd_resp_q;
            n                = n + 2'd1;
        end
        cnt_d = n;
    end

    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_waddr] <= bd_wdata;
        end
        if (rd_en) begin
            mem_rdat_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            waddr_q    <= '0;
            id_q       <= '0;
            len_q      <= 8'd0;
            beat_q     <= 8'd0;
            fixed_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_resp_q  <= 2'b00;
            cnt_q      <= 2'd0;
            buf_dat_q  <= '{default: '0};
            buf_last_q <= '{default: 1'b0};
            buf_resp_q <= '{default: 2'b00};
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            waddr_q    <= waddr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            fixed_q    <= fixed_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            rd_resp_q  <= rd_resp_d;
            cnt_q      <= cnt_d;
            buf_dat_q  <= buf_dat_d;
            buf_last_q <= buf_last_d;
            buf_resp_q <= buf_resp_d;
        end
    end
endmodule

// File: tb/tb_kernel3_gmem_c_s_axi_rd_resp.sv
// Scoreboard bench for the gmem_C read responder: directed bursts push expected beats, a monitor checks R handshakes.
module tb_kernel3_gmem_c_s_axi_rd_resp;
    typedef struct {
        logic [31:0] dat;
        logic        id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_waddr = '0;
    logic [31:0] bd_wdata = '0;

    always #5 clk = ~clk;

    kernel3_gmem_c_s_axi_rd_resp_if bus ();

    kernel3_gmem_c_s_axi_rd_resp dut (
        .clk      (clk),
        .reset    (reset),
        .s        (bus),
        .bd_we    (bd_we),
        .bd_waddr (bd_waddr),
        .bd_wdata (bd_wdata)
    );

    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    rr_mode = 0;
    int    rr_idx = 0;
    int    last_acc_edge = -1;
    int    ar_seen = 0;
    int    hs_edge = 0;
    logic [5:0] pat = 6'b101001;
    beat_t exp_q[$];
    beat_t e;
    bit    stall_v = 1'b0;
    logic [35:0] held;
    logic [35:0] cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic exp_beat(input logic [31:0] dat, input logic id, input logic [1:0] resp, input logic last);
        beat_t b;
        b.dat = dat; b.id = id; b.resp = resp; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_waddr = a; bd_wdata = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic id);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.s_araddr = addr; bus.s_arlen = len; bus.s_arburst = burst; bus.s_arid = id;
        bus.s_arvalid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.s_arready) begin
                got = 1'b1; ar_seen = cyc; hs_edge = cyc + 1;
            end
        end
        if (!got) chk(1'b0, "ar_timeout", 0, 1);
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            chk(1'b0, nm, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // RREADY driver: 0 = held high, 1 = 1,0,0,1,0,1 pattern, 2 = held low.
    initial begin
        bus.s_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                1: begin bus.s_rready = pat[rr_idx]; rr_idx = (rr_idx + 1) % 6; end
                2: bus.s_rready = 1'b0;
                default: bus.s_rready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        cur = {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_rlast};
        if (reset) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v && bus.s_rvalid) chk(cur == held, "r_stable", cur, held);
            if (bus.s_rvalid && bus.s_rready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", bus.s_rdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(bus.s_rdata == e.dat, "rdata", bus.s_rdata, e.dat);
                    chk(bus.s_rid == e.id, "rid", bus.s_rid, e.id);
                    chk(bus.s_rresp == e.resp, "rresp", bus.s_rresp, e.resp);
                    chk(bus.s_rlast == e.last, "rlast", bus.s_rlast, e.last);
                end
                if (bus.s_rlast) last_acc_edge = cyc + 1;
                stall_v = 1'b0;
            end else if (bus.s_rvalid) begin
                stall_v = 1'b1;
                held = cur;
            end else begin
                if (stall_v) chk(1'b0, "rvalid_dropped", 0, 1);
                stall_v = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.s_arvalid = 1'b0; bus.s_araddr = '0; bus.s_arid = '0;
        bus.s_arlen = '0; bus.s_arburst = 2'b01;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(bus.s_arready == 1'b0, "rst_arready", bus.s_arready, 0);
        chk(bus.s_rvalid == 1'b0, "rst_rvalid", bus.s_rvalid, 0);
        chk(bus.s_rlast == 1'b0, "rst_rlast", bus.s_rlast, 0);
        chk(bus.s_rresp == 2'b00, "rst_rresp", bus.s_rresp, 0);
        chk(bus.s_rid == 1'b0, "rst_rid", bus.s_rid, 0);
        chk(bus.s_rdata == 32'h0, "rst_rdata", bus.s_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk(bus.s_arready == 1'b1, "arready_after_rst", bus.s_arready, 1);

        bd_write(10'd0, 32'hA0);
        bd_write(10'd1, 32'hA1);
        bd_write(10'd2, 32'hA2);
        bd_write(10'd3, 32'hA3);
        bd_write(10'd1022, 32'hC3FE);
        bd_write(10'd1023, 32'hC3FF);

        // 1: INCR len=3 at full rate, latency and back-to-back beats
        exp_beat(32'hA0, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA1, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA3, 1'b1, 2'b00, 1'b1);
        do_ar(32'h0, 8'd3, 2'b01, 1'b1);
        @(negedge clk);
        chk(bus.s_rvalid == 1'b0, "lat_T", bus.s_rvalid, 0);
        @(negedge clk);
        chk(bus.s_rvalid == 1'b0, "lat_T1", bus.s_rvalid, 0);
        @(negedge clk);
        chk(bus.s_rvalid == 1'b1, "lat_T2", bus.s_rvalid, 1);
        repeat (3) @(negedge clk);
        #2;
        chk(exp_q.size() == 0, "four_consecutive", exp_q.size(), 0);
        wait_drain("drain_t1");

        // 2: same burst under RREADY backpressure
        rr_mode = 1;
        exp_beat(32'hA0, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA1, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA3, 1'b1, 2'b00, 1'b1);
        do_ar(32'h0, 8'd3, 2'b01, 1'b1);
        wait_drain("drain_t2");
        rr_mode = 0;

        // 3: FIXED burst, then an unaligned single beat
        exp_beat(32'hA2, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b0, 2'b00, 1'b1);
        do_ar(32'h8, 8'd2, 2'b00, 1'b0);
        wait_drain("drain_t3a");
        exp_beat(32'hA1, 1'b0, 2'b00, 1'b1);
        do_ar(32'h6, 8'd0, 2'b01, 1'b0);
        wait_drain("drain_t3b");

        // 4: second AR held while the first burst is active
        exp_beat(32'hA0, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA1, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA3, 1'b0, 2'b00, 1'b1);
        do_ar(32'h0, 8'd3, 2'b01, 1'b0);
        exp_beat(32'hA1, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA2, 1'b1, 2'b00, 1'b1);
        do_ar(32'h4, 8'd1, 2'b01, 1'b1);
        chk(ar_seen == last_acc_edge, "arready_after_rlast", ar_seen, last_acc_edge);
        wait_drain("drain_t4");

        // 5: reset after beat 1 of a len=7 burst
        exp_beat(32'hA0, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA1, 1'b0, 2'b00, 1'b0);
        do_ar(32'h0, 8'd7, 2'b01, 1'b0);
        wait_drain("drain_t5a");
        reset = 1'b1;
        rr_mode = 2;
        @(negedge clk);
        chk(bus.s_rvalid == 1'b0, "abort_rvalid", bus.s_rvalid, 0);
        chk(bus.s_arready == 1'b0, "abort_arready", bus.s_arready, 0);
        @(negedge clk);
        reset = 1'b0;
        rr_mode = 0;
        @(negedge clk);
        chk(bus.s_arready == 1'b1, "arready_after_abort", bus.s_arready, 1);
        exp_beat(32'hA2, 1'b1, 2'b00, 1'b0);
        exp_beat(32'hA3, 1'b1, 2'b00, 1'b1);
        do_ar(32'h8, 8'd1, 2'b01, 1'b1);
        wait_drain("drain_t5b");

        // 6: burst running off the top of the array
`ifdef KERNEL3_GMEM_C_RD_DECERR_EN
        exp_beat(32'hC3FE, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hC3FF, 1'b0, 2'b00, 1'b0);
        exp_beat(32'h0,    1'b0, 2'b11, 1'b0);
        exp_beat(32'h0,    1'b0, 2'b11, 1'b1);
`else
        exp_beat(32'hC3FE, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hC3FF, 1'b0, 2'b00, 1'b0);
        exp_beat(32'hA0,   1'b0, 2'b00, 1'b0);
        exp_beat(32'hA1,   1'b0, 2'b00, 1'b1);
`endif
        do_ar(32'hFF8, 8'd3, 2'b01, 1'b0);
        wait_drain("drain_t6");

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kernel3_gmem_c_s_axi_rd_resp.md
Name: kernel3_gmem_c_s_axi_rd_resp

Overview:
AXI4 read-channel responder (slave) that serves the gmem_C m_axi read master from an on-chip word array.
- Accepts AR bursts and returns R beats with RLAST at full throughput under RREADY backpressure.
- Used as a synthesizable memory model in kernel-level integration and as a standalone bench target.
- Array is loaded through a simple backdoor write port.

Parameters:
DATA_WIDTH, 32, R data width in bits; power of 2, at least 8.
ADDR_WIDTH, 32, AXI byte-address width.
ID_WIDTH, 1, ARID/RID width.
MEM_AW, 10, word-address width of the array; depth = 2**MEM_AW words.
MEM_STYLE, "auto", ram_style attribute applied to the array.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_araddr  in  ADDR_WIDTH  byte address of first beat
s_arid  in  ID_WIDTH  transaction id
s_arlen  in  8  beats minus 1
s_arburst  in  2  burst type
s_rvalid  out  1  R valid
s_rready  in  1  R ready
s_rdata  out  DATA_WIDTH  read data
s_rid  out  ID_WIDTH  echoed ARID
s_rresp  out  2  response code
s_rlast  out  1  last beat of burst
bd_we  in  1  backdoor write enable
bd_waddr  in  MEM_AW  backdoor word address
bd_wdata  in  DATA_WIDTH  backdoor write data

Behaviour:
- Reset: clk and reset are as decided: clock clk; reset is synchronous, active-high.
  - Reset values: s_arready=0, s_rvalid=0, s_rlast=0, s_rresp=0, s_rid=0, s_rdata=0.
  - Burst counter and the output buffer clear.
  - Reset asserted mid-burst aborts the burst: s_rvalid=0 on the next edge, no further beats, FSM goes to IDLE.
- Word address = araddr[MEM_AW+B-1:B], where B=log2(DATA_WIDTH/8). Low B bits are ignored; unaligned addresses are treated as aligned. ARSIZE is not supported; every beat is full width.
- Address step per beat:
  - s_arburst=2'b00 (FIXED): word address is held for all beats.
  - Any other value: word address increments by 1 per beat; WRAP is treated as INCR.
- FSM states:
  - IDLE: s_arready=1 (registered). A handshake (arvalid&arready) latches addr, id and len. Next state BURST; s_arready=0 from the next cycle.
  - BURST: issues one array read per cycle while the output buffer has space. After the read for beat len is issued, next state DRAIN.
  - DRAIN: waits until the last beat is accepted (rvalid&rready&rlast), then returns to IDLE. s_arready=1 on the cycle after the final beat is accepted.
- Only one outstanding burst at a time; AR is never accepted while a burst is active.
- Latency:
  - Array read is synchronous, one cycle.
  - An AR handshake at edge T gives first s_rvalid=1 after edge T+2.
- Output buffer: 2-entry skid buffer.
  - With s_rready held high, a burst of N beats takes exactly N consecutive rvalid cycles.
  - Array reads stall when an issued read would overflow the buffer. Data, resp and last are never dropped or duplicated.
- R channel:
  - Once s_rvalid=1, s_rdata, s_rid, s_rresp and s_rlast are stable until accepted.
  - s_rlast=1 only on beat arlen; arlen=0 gives a single beat with rlast=1.
  - s_rid equals the latched ARID on every beat.
- Backdoor port: bd_we writes the array at the clock edge. On a same-cycle backdoor write and read of the same word, the read returns the old data.
- s_rresp=2'b00 (OKAY) except as defined under Optional Feature.

Optional Feature:
Macro KERNEL3_GMEM_C_RD_DECERR_EN.
- Defined:
  - A beat is out of range when its byte address bits above MEM_AW+B-1 are nonzero, or when an INCR beat's word address exceeds 2**MEM_AW-1.
  - Out-of-range beats return s_rresp=2'b11 (DECERR) and s_rdata=0.
  - In-range beats of the same burst still return OKAY with data.
- Undefined: the word address wraps modulo 2**MEM_AW, upper address bits are ignored, and s_rresp is always 2'b00.

Test Plan:
1. Backdoor words 0..3 = 0xA0..0xA3; AR addr=0x0 len=3 INCR id=1; rready=1 -> four consecutive beats 0xA0..0xA3, rid=1, rresp=0, rlast only on 0xA3, first rvalid 2 cycles after the AR handshake.
2. Same burst with rready toggling 1,0,0,1,0,1... -> data sequence is unchanged, no beat lost or repeated, each beat held stable while rready=0.
3. AR addr=0x8 len=2 FIXED -> three beats, all equal to word 2; then AR addr=0x6 len=0 -> single beat, word 1 (unaligned low bits ignored), rlast=1.
4. Second arvalid held during an active burst -> s_arready stays 0 until the cycle after the first burst's rlast is accepted; the second burst then completes correctly.
5. Reset asserted after beat 1 of a len=7 burst -> s_rvalid=0 and s_arready=0 next cycle, s_arready=1 after reset deasserts, a new burst returns correct data.
6. With the macro defined, MEM_AW=10: AR word 1022, len=3 INCR -> rresp = 0, 0, 3, 3 and rdata for the last two beats = 0. With the macro undefined, the same burst returns words 1022, 1023, 0, 1, all with rresp=0.
